arf_sequencer: RTL
==================

Name: arf_sequencer

Overview:
Multi-cycle control sequencer for the address register file (PC, AR, SP) and the byte-wide memory port. It arbitrates between instruction fetch and stack requests (PUSH, POP, CALL, RET). Each granted request runs as a fixed sequence of single-register ARF operations, with one ARF op per cycle because the ARF has one shared FunSel. It sits between the control unit and the ARF/memory datapath.

Parameters:
STACK_LIMIT, 16'h0800, lowest byte address the stack may occupy
STACK_TOP, 16'h0FFF, highest byte address the stack may occupy

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
FetchReq  in  1  fetch a 16-bit instruction (2 bytes at PC)
StackReq  in  1  stack operation request
StackOp  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET; stable while StackReq=1
SPValue  in  16  ARF OutD; equals SP whenever the sequencer is in IDLE
FetchDone  out  1  final-cycle pulse of a fetch
StackDone  out  1  final-cycle pulse of a stack op
StackErr  out  1  with StackDone: op rejected by bounds check
Busy  out  1  state != IDLE
ARF_FunSel  out  3  000 dec, 001 inc, 010 load, 101 write low byte, 110 write high byte
ARF_RegSel  out  3  active-low enables: [2] PC, [1] AR, [0] SP
ARF_OutCSel  out  2  drives the memory data source
ARF_OutDSel  out  2  drives the memory address
TargetOE  out  1  ARF I is taken from the jump-target register
MemCS  out  1  memory access this cycle
MemWR  out  1  1 write, 0 read
MemByteSel  out  1  write data byte: 1 high, 0 low
MemDataSel  out  2  00 none, 01 push-data register, 10 ARF OutC
IRLoadL, IRLoadH  out  1 each  IR byte loads from memory read data
DstLoadL, DstLoadH  out  1 each  pop-destination byte loads from memory read data

Behaviour:
- Moore FSM. All outputs decode combinationally from the current state. The ARF, memory and load registers act on the rising edge that ends the state.
- Default outputs (IDLE, ERR, and after Reset): RegSel=111, FunSel=000, OutCSel=11, OutDSel=11, every strobe 0, MemDataSel=00.
- Reset: state returns to IDLE immediately. An in-flight op aborts; ARF/memory changes already clocked stay as they are, with no rollback.
- IDLE arbitration:
  - StackReq has priority over FetchReq.
  - The bounds check runs in IDLE using SPValue, computed in 17 bits so there is no wrap.
  - PUSH/CALL are legal iff SPValue-1 >= STACK_LIMIT.
  - POP/RET are legal iff SPValue+2 <= STACK_TOP.
  - An illegal op goes to ERR.
- SP convention: SP points to the first free byte. The stack grows down, and the low byte sits at the lower address.
- State sequences (MemCS=1 on every listed memory access; address from OutD):
  - F_L: OutDSel=00, read, IRLoadL, PC inc → F_H.
  - F_H: read, IRLoadH, PC inc, FetchDone → IDLE.
  - PU_H: OutDSel=11, write, MemDataSel=01, ByteSel=1, SP dec → PU_L.
  - PU_L: same with ByteSel=0, StackDone → IDLE.
  - PO_I: SP inc → PO_L.
  - PO_L: OutDSel=11, read, DstLoadL, SP inc → PO_H.
  - PO_H: read, DstLoadH, StackDone → IDLE.
  - CA_H: OutCSel=00, MemDataSel=10, ByteSel=1, write, SP dec → CA_L.
  - CA_L: same with ByteSel=0 → CA_J.
  - CA_J: TargetOE, PC load (010), StackDone → IDLE.
  - RE_I: SP inc → RE_L.
  - RE_L: OutDSel=11, read, PC write-low (101) → RE_S.
  - RE_S: SP inc → RE_H.
  - RE_H: read, PC write-high (110), StackDone → IDLE.
  - ERR: StackDone=1, StackErr=1, no ARF/memory activity → IDLE.
- Latencies in cycles, excluding the IDLE cycle: fetch 2, push 2, pop 3, call 3, ret 4, error 1.
- Handshake:
  - A requester holds Req until it samples its Done, and drops Req on that same edge.
  - A Req still high in IDLE afterwards is serviced again.
  - At least one IDLE cycle separates consecutive operations.
- Simultaneous FetchReq and StackReq: the stack op runs first and the fetch waits (FetchDone stays 0).
- StackOp changes while Busy are ignored; the op is latched in the IDLE decision.
- Only one ARF register is enabled in any cycle.

Decomposition:
- Package arf_seq_pkg holds:
  - the state enum;
  - the FunSel codes (DEC, INC, LOAD, WLO, WHI);
  - the RegSel one-cold constants (SEL_PC, SEL_AR, SEL_SP, SEL_NONE);
  - the Out*Sel codes;
  - the StackOp codes;
  - the MemDataSel codes.
- Sub-module arf_stack_guard: combinational 17-bit bounds check (SPValue, op → legal), parameterised by STACK_LIMIT/STACK_TOP.

Test Plan:
- Reset mid-PO_L, then release: next cycle is IDLE, all outputs at their defaults, Busy=0.
- FetchReq with PC=0x0010, mem[0x10]=0x34, mem[0x11]=0x12 → IR=0x1234, PC=0x0012, FetchDone in cycle 2.
- PUSH with SP=0x0FFF, data 0xBEEF → mem[0x0FFF]=0xBE, mem[0x0FFE]=0xEF, SP=0x0FFD; then POP → Dst=0xBEEF, SP=0x0FFF.
- CALL with PC=0x0200, SP=0x0F00, target 0x0400 → mem[0x0F00]=0x02, mem[0x0EFF]=0x00, PC=0x0400, SP=0x0EFE, StackDone in cycle 3; then RET → PC=0x0200, SP=0x0F00.
- PUSH with SP=0x0800, and POP with SP=0x0FFE → ERR for one cycle, StackErr=1, SP/memory unchanged.
- FetchReq and StackReq (PUSH) asserted together → push completes first, then fetch; no cycle enables two RegSel bits.

Source files
------------

// File: rtl/arf_seq_pkg.sv
// Shared encodings for the ARF/memory control sequencer: states, ARF select
// and function codes, stack op codes and the packed control-output bundle.
package arf_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_L,
        S_F_H,
        S_PU_H,
        S_PU_L,
        S_PO_I,
        S_PO_L,
        S_PO_H,
        S_CA_H,
        S_CA_L,
        S_CA_J,
        S_RE_I,
        S_RE_L,
        S_RE_S,
        S_RE_H,
        S_ERR
    } state_t;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_WLO  = 3'b101;
    localparam logic [2:0] FS_WHI  = 3'b110;

    // Active-low register enables, bit 2 = PC, bit 1 = AR, bit 0 = SP.
    localparam logic [2:0] SEL_PC   = 3'b011;
    localparam logic [2:0] SEL_AR   = 3'b101;
    localparam logic [2:0] SEL_SP   = 3'b110;
    localparam logic [2:0] SEL_NONE = 3'b111;

    localparam logic [1:0] OSEL_PC = 2'b00;
    localparam logic [1:0] OSEL_AR = 2'b01;
    localparam logic [1:0] OSEL_SP = 2'b11;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [1:0] MDS_NONE = 2'b00;
    localparam logic [1:0] MDS_PUSH = 2'b01;
    localparam logic [1:0] MDS_OUTC = 2'b10;

    typedef struct packed {
        logic       fetch_done;
        logic       stack_done;
        logic       stack_err;
        logic [2:0] funsel;
        logic [2:0] regsel;
        logic [1:0] outcsel;
        logic [1:0] outdsel;
        logic       target_oe;
        logic       mem_cs;
        logic       mem_wr;
        logic       byte_sel;
        logic [1:0] mem_data_sel;
        logic       ir_load_l;
        logic       ir_load_h;
        logic       dst_load_l;
        logic       dst_load_h;
    } ctl_t;

    localparam ctl_t CTL_DEFAULT = '{
        fetch_done:   1'b0,
        stack_done:   1'b0,
        stack_err:    1'b0,
        funsel:       FS_DEC,
        regsel:       SEL_NONE,
        outcsel:      OSEL_SP,
        outdsel:      OSEL_SP,
        target_oe:    1'b0,
        mem_cs:       1'b0,
        mem_wr:       1'b0,
        byte_sel:     1'b0,
        mem_data_sel: MDS_NONE,
        ir_load_l:    1'b0,
        ir_load_h:    1'b0,
        dst_load_l:   1'b0,
        dst_load_h:   1'b0
    };

    // PUSH and CALL grow the stack downward; POP and RET shrink it.
    function automatic logic op_grows(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/arf_stack_guard.sv
// Combinational stack bounds check, evaluated against SP while the sequencer
// is idle. Arithmetic is 17 bits wide so neither direction can wrap.
module arf_stack_guard
    import arf_seq_pkg::*;
#(
    parameter logic [15:0] STACK_LIMIT = 16'h0800,
    parameter logic [15:0] STACK_TOP   = 16'h0FFF
) (
    input  logic [15:0] i_sp_value,
    input  logic [1:0]  i_stack_op,
    output logic        o_legal
);

    logic [16:0] w_sp;
    logic [16:0] w_push_min;
    logic [16:0] w_pop_next;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign w_sp = {1'b0, i_sp_value};

    // SP-1 >= LIMIT is evaluated as SP >= LIMIT+1 so SP=0 cannot underflow.
    assign w_push_min = {1'b0, STACK_LIMIT} + 17'd1;
    assign w_pop_next = w_sp + 17'd2;

    assign w_push_ok = (w_sp >= w_push_min);
    assign w_pop_ok  = (w_pop_next <= {1'b0, STACK_TOP});

    assign o_legal = op_grows(i_stack_op) ? w_push_ok : w_pop_ok;

endmodule

// File: rtl/arf_sequencer.sv
// Moore sequencer that turns fetch and stack requests into one-register-per-
// cycle ARF operations plus byte-wide memory accesses.
module arf_sequencer
    import arf_seq_pkg::*;
#(
    parameter logic [15:0] STACK_LIMIT = 16'h0800,
    parameter logic [15:0] STACK_TOP   = 16'h0FFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic        i_stack_req,
    input  logic [1:0]  i_stack_op,
    input  logic [15:0] i_sp_value,
    output logic        o_fetch_done,
    output logic        o_stack_done,
    output logic        o_stack_err,
    output logic        o_busy,
    output logic [2:0]  o_arf_funsel,
    output logic [2:0]  o_arf_regsel,
    output logic [1:0]  o_arf_outcsel,
    output logic [1:0]  o_arf_outdsel,
    output logic        o_target_oe,
    output logic        o_mem_cs,
    output logic        o_mem_wr,
    output logic        o_mem_byte_sel,
    output logic [1:0]  o_mem_data_sel,
    output logic        o_ir_load_l,
    output logic        o_ir_load_h,
    output logic        o_dst_load_l,
    output logic        o_dst_load_h,
    output logic [3:0]  o_state
);

    // Handshake: a requester holds its Req high until it samples the matching
    // Done pulse and drops Req on that same edge; every op returns to IDLE,
    // so a Req still high there is taken as a new request.

    state_t r_state;
    state_t w_next_state;
    ctl_t   w_ctl;
    logic   w_legal;

    arf_stack_guard #(
        .STACK_LIMIT (STACK_LIMIT),
        .STACK_TOP   (STACK_TOP)
    ) u_guard (
        .i_sp_value (i_sp_value),
        .i_stack_op (i_stack_op),
        .o_legal    (w_legal)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The op code is consumed only here; the chosen state carries it onward.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_stack_req) begin
                    if (!w_legal) begin
                        w_next_state = S_ERR;
                    end else begin
                        case (i_stack_op)
                            OP_PUSH: w_next_state = S_PU_H;
                            OP_POP:  w_next_state = S_PO_I;
                            OP_CALL: w_next_state = S_CA_H;
                            default: w_next_state = S_RE_I;
                        endcase
                    end
                end else if (i_fetch_req) begin
                    w_next_state = S_F_L;
                end
            end
            S_F_L:   w_next_state = S_F_H;
            S_F_H:   w_next_state = S_IDLE;
            S_PU_H:  w_next_state = S_PU_L;
            S_PU_L:  w_next_state = S_IDLE;
            S_PO_I:  w_next_state = S_PO_L;
            S_PO_L:  w_next_state = S_PO_H;
            S_PO_H:  w_next_state = S_IDLE;
            S_CA_H:  w_next_state = S_CA_L;
            S_CA_L:  w_next_state = S_CA_J;
            S_CA_J:  w_next_state = S_IDLE;
            S_RE_I:  w_next_state = S_RE_L;
            S_RE_L:  w_next_state = S_RE_S;
            S_RE_S:  w_next_state = S_RE_H;
            S_RE_H:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_ctl = CTL_DEFAULT;
        case (r_state)
            S_F_L: begin
                w_ctl.outdsel   = OSEL_PC;
                w_ctl.mem_cs    = 1'b1;
                w_ctl.ir_load_l = 1'b1;
                w_ctl.regsel    = SEL_PC;
                w_ctl.funsel    = FS_INC;
            end
            S_F_H: begin
                w_ctl.outdsel    = OSEL_PC;
                w_ctl.mem_cs     = 1'b1;
                w_ctl.ir_load_h  = 1'b1;
                w_ctl.regsel     = SEL_PC;
                w_ctl.funsel     = FS_INC;
                w_ctl.fetch_done = 1'b1;
            end
            S_PU_H: begin
                w_ctl.outdsel      = OSEL_SP;
                w_ctl.mem_cs       = 1'b1;
                w_ctl.mem_wr       = 1'b1;
                w_ctl.mem_data_sel = MDS_PUSH;
                w_ctl.byte_sel     = 1'b1;
                w_ctl.regsel       = SEL_SP;
                w_ctl.funsel       = FS_DEC;
            end
            S_PU_L: begin
                w_ctl.outdsel      = OSEL_SP;
                w_ctl.mem_cs       = 1'b1;
                w_ctl.mem_wr       = 1'b1;
                w_ctl.mem_data_sel = MDS_PUSH;
                w_ctl.byte_sel     = 1'b0;
                w_ctl.regsel       = SEL_SP;
                w_ctl.funsel       = FS_DEC;
                w_ctl.stack_done   = 1'b1;
            end
            S_PO_I, S_RE_I, S_RE_S: begin
                w_ctl.regsel = SEL_SP;
                w_ctl.funsel = FS_INC;
            end
            S_PO_L: begin
                w_ctl.outdsel    = OSEL_SP;
                w_ctl.mem_cs     = 1'b1;
                w_ctl.dst_load_l = 1'b1;
                w_ctl.regsel     = SEL_SP;
                w_ctl.funsel     = FS_INC;
            end
            S_PO_H: begin
                w_ctl.outdsel    = OSEL_SP;
                w_ctl.mem_cs     = 1'b1;
                w_ctl.dst_load_h = 1'b1;
                w_ctl.stack_done = 1'b1;
            end
            S_CA_H: begin
                w_ctl.outcsel      = OSEL_PC;
                w_ctl.outdsel      = OSEL_SP;
                w_ctl.mem_cs       = 1'b1;
                w_ctl.mem_wr       = 1'b1;
                w_ctl.mem_data_sel = MDS_OUTC;
                w_ctl.byte_sel     = 1'b1;
                w_ctl.regsel       = SEL_SP;
                w_ctl.funsel       = FS_DEC;
            end
            S_CA_L: begin
                w_ctl.outcsel      = OSEL_PC;
                w_ctl.outdsel      = OSEL_SP;
                w_ctl.mem_cs       = 1'b1;
                w_ctl.mem_wr       = 1'b1;
                w_ctl.mem_data_sel = MDS_OUTC;
                w_ctl.byte_sel     = 1'b0;
                w_ctl.regsel       = SEL_SP;
                w_ctl.funsel       = FS_DEC;
            end
            S_CA_J: begin
                w_ctl.target_oe  = 1'b1;
                w_ctl.regsel     = SEL_PC;
                w_ctl.funsel     = FS_LOAD;
                w_ctl.stack_done = 1'b1;
            end
            S_RE_L: begin
                w_ctl.outdsel = OSEL_SP;
                w_ctl.mem_cs  = 1'b1;
                w_ctl.regsel  = SEL_PC;
                w_ctl.funsel  = FS_WLO;
            end
            S_RE_H: begin
                w_ctl.outdsel    = OSEL_SP;
                w_ctl.mem_cs     = 1'b1;
                w_ctl.regsel     = SEL_PC;
                w_ctl.funsel     = FS_WHI;
                w_ctl.stack_done = 1'b1;
            end
            S_ERR: begin
                w_ctl.stack_done = 1'b1;
                w_ctl.stack_err  = 1'b1;
            end
            default: w_ctl = CTL_DEFAULT;
        endcase
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_state        = r_state;
    assign o_fetch_done   = w_ctl.fetch_done;
    assign o_stack_done   = w_ctl.stack_done;
    assign o_stack_err    = w_ctl.stack_err;
    assign o_arf_funsel   = w_ctl.funsel;
    assign o_arf_regsel   = w_ctl.regsel;
    assign o_arf_outcsel  = w_ctl.outcsel;
    assign o_arf_outdsel  = w_ctl.outdsel;
    assign o_target_oe    = w_ctl.target_oe;
    assign o_mem_cs       = w_ctl.mem_cs;
    assign o_mem_wr       = w_ctl.mem_wr;
    assign o_mem_byte_sel = w_ctl.byte_sel;
    assign o_mem_data_sel = w_ctl.mem_data_sel;
    assign o_ir_load_l    = w_ctl.ir_load_l;
    assign o_ir_load_h    = w_ctl.ir_load_h;
    assign o_dst_load_l   = w_ctl.dst_load_l;
    assign o_dst_load_h   = w_ctl.dst_load_h;

endmodule
